// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single Common Data Bus; registered CDB packet.
// Optional CDB_ARB_MEM_PRIORITY_EN: MEM (top index) priority with anti-starvation.
module cdb_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*XLEN-1:0]    req_value,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [XLEN-1:0]            cdb_value,
  output logic [$clog2(NUM_REQ)-1:0] cdb_src,
  output logic [STALL_CNT_W-1:0]     stall_cycles
);

  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] ptr_t;
  localparam ptr_t LAST = ptr_t'(NUM_REQ - 1);

  function automatic ptr_t wrap_add(ptr_t p, int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ptr_t'(s);
  endfunction

  ptr_t                   rr_ptr_q, rr_ptr_d;
  logic                   cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]       cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]        cdb_value_q, cdb_value_d;
  ptr_t                   cdb_src_q, cdb_src_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic rr_any;
  ptr_t rr_idx;
  ptr_t scan_idx;
  logic sel_any;
  ptr_t sel_idx;
  logic accept;
  logic xfer;
  logic contend;

  always_comb begin
    rr_any   = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = wrap_add(rr_ptr_q, k);
      if (!rr_any && req_valid[scan_idx]) begin
        rr_any = 1'b1;
        rr_idx = scan_idx;
      end
    end
  end

`ifdef CDB_ARB_MEM_PRIORITY_EN
  logic [NUM_REQ-2:0][2:0] wait_q, wait_d;
  logic                    starve_any;
  ptr_t                    starve_idx;

  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      if (!starve_any && req_valid[i] && wait_q[i] == 3'd7) begin
        starve_any = 1'b1;
        starve_idx = ptr_t'(i);
      end
    end
  end

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    unique case (1'b1)
      starve_any: begin
        sel_any = 1'b1;
        sel_idx = starve_idx;
      end
      req_valid[NUM_REQ-1]: begin
        sel_any = 1'b1;
        sel_idx = LAST;
      end
      default: begin
        sel_any = rr_any;
        sel_idx = rr_idx;
      end
    endcase
  end

  // Waiting counts any cycle valid-but-not-granted, including flush cycles.
  always_comb begin
    wait_d = '0;
    for (int i = 0; i < NUM_REQ - 1; i++) begin
      if (req_valid[i] && !(xfer && sel_idx == ptr_t'(i))) begin
        wait_d[i] = (wait_q[i] == 3'd7) ? 3'd7 : wait_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  always_comb begin
    sel_any = rr_any;
    sel_idx = rr_idx;
  end
`endif

  assign accept = reset_n && !flush;
  assign xfer   = accept && sel_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (sel_idx == ptr_t'(i));
    end
  end

  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + int'(req_valid[i]);
    end
    contend = (cnt >= 2);
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    stall_d     = stall_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (xfer) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = req_tag[int'(sel_idx)*TAG_W +: TAG_W];
      cdb_value_d = req_value[int'(sel_idx)*XLEN +: XLEN];
      cdb_src_d   = sel_idx;
`ifdef CDB_ARB_MEM_PRIORITY_EN
      if (sel_idx != LAST) rr_ptr_d = sel_idx + 1'b1;
`else
      rr_ptr_d = (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
`endif
    end
    if (!flush && contend && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
      stall_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
      stall_q     <= stall_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_value    = cdb_value_q;
  assign cdb_src      = cdb_src_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
// Narrow stall counter keeps the saturation run short.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int TW = 5;
  localparam int SW = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*XL-1:0] req_value;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [XL-1:0]   cdb_value;
  logic [1:0]      cdb_src;
  logic [SW-1:0]   stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  cdb_arbiter #(
    .NUM_REQ(N), .XLEN(XL), .TAG_W(TW), .STALL_CNT_W(SW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag),
    .req_value(req_value), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] e;
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]   = TW'(16 + i);
      req_value[i*XL +: XL] = 32'hC0DE_0000 + XL'(i);
    end
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    cyc();
    cyc();
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    chk("rst_tag", 64'(cdb_tag), 64'h0);
    chk("rst_src", 64'(cdb_src), 64'h0);
    chk("rst_stall", 64'(stall_cycles), 64'h0);
    chk("rst_ready2", 64'(req_ready), 64'h0);
    reset_n = 1'b1;

`ifdef CDB_ARB_MEM_PRIORITY_EN
    req_valid = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      e = (k < 7) ? 4'b1000 : 4'b0001;
      #1;
      chk("mem_ready", 64'(req_ready), 64'(e));
      cyc();
      chk("mem_src", 64'(cdb_src), (k < 7) ? 64'd3 : 64'd0);
    end
    req_valid = 4'b0011;
    #1;
    chk("mem_rrptr", 64'(req_ready), 64'b0010);
    req_valid = 4'b0000;
    cyc();
`else
    for (int k = 0; k < 8; k++) begin
      e = 4'b0001 << (k % 4);
      #1;
      chk("rr_ready", 64'(req_ready), 64'(e));
      cyc();
      chk("rr_valid", 64'(cdb_valid), 64'h1);
      chk("rr_src", 64'(cdb_src), 64'(k % 4));
      chk("rr_tag", 64'(cdb_tag), 64'(16 + k % 4));
    end
    chk("rr_stall", 64'(stall_cycles), 64'd8);
    req_valid = 4'b0000;
    #1;
    chk("idle_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("idle_valid", 64'(cdb_valid), 64'h0);
    chk("idle_tag", 64'(cdb_tag), 64'd19);

    req_tag[2*TW +: TW]   = 5'd9;
    req_value[2*XL +: XL] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    #1;
    chk("one_ready", 64'(req_ready), 64'b0100);
    cyc();
    chk("one_valid", 64'(cdb_valid), 64'h1);
    chk("one_tag", 64'(cdb_tag), 64'd9);
    chk("one_value", 64'(cdb_value), 64'hDEAD_BEEF);
    chk("one_src", 64'(cdb_src), 64'd2);
    req_valid = 4'b0000;
    cyc();
    chk("one_drop", 64'(cdb_valid), 64'h0);

    req_valid = 4'b0011;
    #1;
    chk("wrap_ready0", 64'(req_ready), 64'b0001);
    cyc();
    chk("wrap_src0", 64'(cdb_src), 64'd0);
    #1;
    chk("wrap_ready1", 64'(req_ready), 64'b0010);
    cyc();
    chk("wrap_src1", 64'(cdb_src), 64'd1);
    chk("wrap_stall", 64'(stall_cycles), 64'd10);

    req_valid = 4'b0100;
    #1;
    chk("fl_grant", 64'(req_ready), 64'b0100);
    cyc();
    flush     = 1'b1;
    req_valid = 4'b1000;
    #1;
    chk("fl_ready", 64'(req_ready), 64'h0);
    chk("fl_pkt", 64'(cdb_valid), 64'h1);
    chk("fl_pktsrc", 64'(cdb_src), 64'd2);
    cyc();
    chk("fl_valid", 64'(cdb_valid), 64'h0);
    chk("fl_tag", 64'(cdb_tag), 64'd9);
    flush     = 1'b0;
    req_valid = 4'b1001;
    #1;
    chk("fl_ptr0", 64'(req_ready), 64'b0001);
    flush     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("fl_ready2", 64'(req_ready), 64'h0);
    cyc();
    chk("fl_nostall", 64'(stall_cycles), 64'd10);
    flush     = 1'b0;
    req_valid = 4'b0000;
    cyc();
`endif

    req_valid = 4'b0010;
    #1;
    chk("mid_grant", 64'(req_ready), 64'b0010);
    cyc();
    chk("mid_valid", 64'(cdb_valid), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("mid_drop", 64'(cdb_valid), 64'h0);
    chk("mid_value", 64'(cdb_value), 64'h0);
    chk("mid_stall", 64'(stall_cycles), 64'h0);

    reset_n   = 1'b1;
    req_valid = 4'b1111;
    repeat (254) cyc();
    chk("sat_fe", 64'(stall_cycles), 64'hFE);
    repeat (3) cyc();
    chk("sat_ff", 64'(stall_cycles), 64'hFF);
    req_valid = 4'b0000;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
